// File: rtl/mem_port_initiator.sv
// mem_port_initiator: initiator side of one RAM port, load/store strobes, buffered load responses, done pulse
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ld_addr/_valid/_ready           load request channel
//   ld_data/_valid/_ready           load response channel (FIFO head)
//   st_addr/st_data/_valid/_ready   store request channel
//   end_valid/end_ready             end-of-kernel token
//   ce/we/address/mem_din/mem_dout  RAM port strobes and data
//   done                            one-cycle pulse once all traffic has drained after end
//
// Optional feature: define RR_ARB_EN for round-robin load/store arbitration;
// the default build uses fixed load-over-store priority.
module mem_port_initiator #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic                  ld_addr_valid,
  output logic                  ld_addr_ready,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_data_valid,
  input  logic                  ld_data_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic                  end_valid,
  output logic                  end_ready,
  output logic                  ce,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  done
);
  localparam int CW = $clog2(RSP_DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(RSP_DEPTH);
  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
  logic [CW-1:0]         r_wp;
  logic [CW-1:0]         r_rp;
  logic [CW:0]           r_cnt;
  logic                  r_inflight;
  logic                  r_done;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_credit;
  logic                  w_ld_req;
  logic                  w_ld_gnt;
  logic                  w_st_gnt;
  logic [CW:0]           w_used;
`ifdef RR_ARB_EN
  logic                  r_ptr;
`endif
  assign w_valid = r_cnt != '0;
  assign w_pop   = w_valid & ld_data_ready;
  // A same-cycle pop frees its slot, so a full-rate stream keeps one load per cycle
  assign w_used   = r_cnt + {{CW{1'b0}}, r_inflight};
  assign w_credit = (w_used - {{CW{1'b0}}, w_pop}) < DEPTH_C;
  assign w_ld_req = ld_addr_valid & w_credit;
  // rst_n gates the grants so ce/we stay low throughout reset
`ifdef RR_ARB_EN
  // r_ptr: 0 favours load, 1 favours store on a simultaneous request
  assign w_ld_gnt = rst_n & w_ld_req & (~st_valid | ~r_ptr);
  assign w_st_gnt = rst_n & st_valid & (~w_ld_req | r_ptr);
`else
  assign w_ld_gnt = rst_n & w_ld_req;
  assign w_st_gnt = rst_n & st_valid & ~w_ld_req;
`endif
  assign ld_addr_ready = w_ld_gnt;
  assign st_ready      = w_st_gnt;
  assign ce            = w_ld_gnt | w_st_gnt;
  assign we            = w_st_gnt;
  assign address       = w_st_gnt ? st_addr : ld_addr;
  assign mem_din       = st_data;
  assign ld_data       = r_mem[r_rp];
  assign ld_data_valid = w_valid;
  assign done          = r_done;
  assign end_ready     = r_done;
  // RAM output is valid the cycle after the grant, which is exactly when r_inflight is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) r_mem[i] <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_ld_gnt;
      if (r_inflight) begin
        r_mem[r_wp] <= mem_dout;
        r_wp        <= r_wp + CW'(1);
      end
      if (w_pop) r_rp <= r_rp + CW'(1);
      r_cnt <= r_cnt + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
`ifndef SYNTHESIS
      if (r_inflight && !w_pop && r_cnt == DEPTH_C) $error("mem_port_initiator: response FIFO overflow");
`endif
    end
  end
`ifdef RR_ARB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= 1'b0;
    else if (w_ld_gnt) r_ptr <= 1'b1;
    else if (w_st_gnt) r_ptr <= 1'b0;
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: if (end_valid) r_state <= S_DRAIN;
        S_DRAIN:
          if (!ld_addr_valid && !st_valid && !r_inflight && !w_valid) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        default: begin
          r_state <= S_RUN;
          r_done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
